// File: rtl/id_ex_issue.sv
// ID/EX pipeline register and operand-issue stage feeding the EX-stage ALU.
// Holds the decoded instruction, forwards EX/MEM and MEM/WB results, and stalls ID on load-use.
module id_ex_issue #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [3:0]      id_alu_ctrl,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_sel_imm,
    input  logic            id_sel_pc,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            flush,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    output logic            stall_id,
    output logic            ex_valid,
    output logic [3:0]      ex_alu_ctrl,
    output logic [XLEN-1:0] ex_op_A,
    output logic [XLEN-1:0] ex_op_B,
    output logic [XLEN-1:0] ex_store_data,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic [XLEN-1:0] ex_pc
);

    logic            valid_q, valid_d;
    logic [3:0]      alu_ctrl_q, alu_ctrl_d;
    logic [RA_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic            use_rs1_q, use_rs1_d, use_rs2_q, use_rs2_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d, pc_q, pc_d;
    logic            sel_imm_q, sel_imm_d, sel_pc_q, sel_pc_d;
    logic            reg_write_q, reg_write_d, mem_read_q, mem_read_d;
    logic            hz_s;
    logic [XLEN-1:0] fa_s, fb_s;

    // Youngest producer wins; x0 is hard-wired zero and never forwarded.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic            use_b,
        input logic [RA_W-1:0] rs,
        input logic [XLEN-1:0] rf_data,
        input logic [RA_W-1:0] m_rd,
        input logic            m_we,
        input logic [XLEN-1:0] m_res,
        input logic [RA_W-1:0] w_rd,
        input logic            w_we,
        input logic [XLEN-1:0] w_res
    );
        logic [XLEN-1:0] r;
        if (use_b && m_we && (m_rd != {RA_W{1'b0}}) && (m_rd == rs)) begin
            r = m_res;
        end else if (use_b && w_we && (w_rd != {RA_W{1'b0}}) && (w_rd == rs)) begin
            r = w_res;
        end else begin
            r = rf_data;
        end
        return r;
    endfunction

    // Load-use hazard detection and ID stall request
    always_comb begin
        hz_s = valid_q & mem_read_q & (rd_q != {RA_W{1'b0}}) & id_valid &
               ((id_use_rs1 & (id_rs1 == rd_q)) | (id_use_rs2 & (id_rs2 == rd_q)));
        stall_id = hz_s & ~flush;
    end

    // Next-state selection: flush beats bubble beats normal load
    always_comb begin
        valid_d     = valid_q;
        alu_ctrl_d  = alu_ctrl_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        use_rs1_d   = use_rs1_q;
        use_rs2_d   = use_rs2_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        sel_imm_d   = sel_imm_q;
        sel_pc_d    = sel_pc_q;
        pc_d        = pc_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (hz_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d     = id_valid;
            alu_ctrl_d  = id_alu_ctrl;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            use_rs1_d   = id_use_rs1;
            use_rs2_d   = id_use_rs2;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            sel_imm_d   = id_sel_imm;
            sel_pc_d    = id_sel_pc;
            pc_d        = id_pc;
            rd_d        = id_rd;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            alu_ctrl_q  <= 4'd0;
            rs1_q       <= {RA_W{1'b0}};
            rs2_q       <= {RA_W{1'b0}};
            use_rs1_q   <= 1'b0;
            use_rs2_q   <= 1'b0;
            rs1_data_q  <= {XLEN{1'b0}};
            rs2_data_q  <= {XLEN{1'b0}};
            imm_q       <= {XLEN{1'b0}};
            sel_imm_q   <= 1'b0;
            sel_pc_q    <= 1'b0;
            pc_q        <= {XLEN{1'b0}};
            rd_q        <= {RA_W{1'b0}};
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            alu_ctrl_q  <= alu_ctrl_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            use_rs1_q   <= use_rs1_d;
            use_rs2_q   <= use_rs2_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            sel_imm_q   <= sel_imm_d;
            sel_pc_q    <= sel_pc_d;
            pc_q        <= pc_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
        end
    end

    // Forwarded operands and ALU-facing outputs
    always_comb begin
        fa_s = fwd_sel(use_rs1_q, rs1_q, rs1_data_q, mem_rd, mem_reg_write, mem_result,
                       wb_rd, wb_reg_write, wb_result);
        fb_s = fwd_sel(use_rs2_q, rs2_q, rs2_data_q, mem_rd, mem_reg_write, mem_result,
                       wb_rd, wb_reg_write, wb_result);
        ex_op_A       = sel_pc_q ? pc_q : fa_s;
        ex_op_B       = sel_imm_q ? imm_q : fb_s;
        ex_store_data = fb_s;
        ex_valid      = valid_q;
        ex_alu_ctrl   = alu_ctrl_q;
        ex_rd         = rd_q;
        ex_pc         = pc_q;
        ex_reg_write  = valid_q & reg_write_q;
        ex_mem_read   = valid_q & mem_read_q;
    end

endmodule

// File: tb/tb_id_ex_issue.sv
// Self-checking bench for id_ex_issue: vector table, hand sequences for hazards/flush/reset,
// and randomized traffic against a reference model.
module tb_id_ex_issue;

    typedef struct packed {
        logic        valid;
        logic [3:0]  alu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use1;
        logic        use2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic        sel_imm;
        logic        sel_pc;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
    } instr_t;

    typedef struct packed {
        instr_t      ins;
        logic [4:0]  mrd;
        logic        mwe;
        logic [31:0] mres;
        logic [4:0]  wrd;
        logic        wwe;
        logic [31:0] wres;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_st;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid, id_use_rs1, id_use_rs2, id_sel_imm, id_sel_pc, id_reg_write, id_mem_read;
    logic [3:0]  id_alu_ctrl;
    logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc, mem_result, wb_result;
    logic        flush, mem_reg_write, wb_reg_write;
    logic        stall_id, ex_valid, ex_reg_write, ex_mem_read;
    logic [3:0]  ex_alu_ctrl;
    logic [31:0] ex_op_A, ex_op_B, ex_store_data, ex_pc;
    logic [4:0]  ex_rd;

    int passed = 0;
    int total  = 0;

    id_ex_issue #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_alu_ctrl(id_alu_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_sel_imm(id_sel_imm), .id_sel_pc(id_sel_pc), .id_pc(id_pc), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_op_A(ex_op_A), .ex_op_B(ex_op_B), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_pc(ex_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic apply_id(input instr_t t);
        id_valid = t.valid;     id_alu_ctrl = t.alu;   id_rs1 = t.rs1;       id_rs2 = t.rs2;
        id_use_rs1 = t.use1;    id_use_rs2 = t.use2;   id_rs1_data = t.d1;   id_rs2_data = t.d2;
        id_imm = t.imm;         id_sel_imm = t.sel_imm; id_sel_pc = t.sel_pc; id_pc = t.pc;
        id_rd = t.rd;           id_reg_write = t.rw;   id_mem_read = t.mr;
    endtask

    task automatic set_fwd(input logic [4:0] mrd, input logic mwe, input logic [31:0] mres,
                           input logic [4:0] wrd, input logic wwe, input logic [31:0] wres);
        mem_rd = mrd; mem_reg_write = mwe; mem_result = mres;
        wb_rd = wrd;  wb_reg_write = wwe;  wb_result = wres;
    endtask

    function automatic instr_t mk(input logic [3:0] alu, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic u1, input logic u2, input logic [31:0] d1,
                                  input logic [31:0] d2, input logic [4:0] rd, input logic mr);
        instr_t t;
        t = '0;
        t.valid = 1'b1; t.alu = alu; t.rs1 = rs1; t.rs2 = rs2; t.use1 = u1; t.use2 = u2;
        t.d1 = d1; t.d2 = d2; t.rd = rd; t.rw = 1'b1; t.mr = mr; t.pc = 32'h0000_0040;
        return t;
    endfunction

    // Reference: value an operand should see, from the register file or the newest in-flight writer.
    function automatic logic [31:0] ref_operand(input logic use_b, input logic [4:0] rs,
                                                input logic [31:0] rf);
        if (use_b && rs != 5'd0 && mem_reg_write && mem_rd == rs) return mem_result;
        if (use_b && rs != 5'd0 && wb_reg_write && wb_rd == rs) return wb_result;
        return rf;
    endfunction

    vec_t   vecs[7];
    instr_t m_ex, cur, t;
    logic   cur_flush, exp_hz, exp_stall;
    logic [31:0] ea, eb;

    initial begin
        apply_id('0);
        flush = 1'b0;
        set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);

        // {ins, mem_rd, mem_we, mem_res, wb_rd, wb_we, wb_res, exp_a, exp_b, exp_store}
        vecs[0] = '{mk(4'd0, 5'd1, 5'd2, 1'b1, 1'b1, 32'd5, 32'd7, 5'd7, 1'b0),
                    5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd5, 32'd7, 32'd7};
        vecs[1] = '{mk(4'd1, 5'd3, 5'd2, 1'b1, 1'b1, 32'h33, 32'h44, 5'd7, 1'b0),
                    5'd3, 1'b1, 32'h10, 5'd3, 1'b1, 32'h20, 32'h10, 32'h44, 32'h44};
        vecs[2] = '{mk(4'd1, 5'd3, 5'd2, 1'b1, 1'b1, 32'h33, 32'h44, 5'd7, 1'b0),
                    5'd3, 1'b0, 32'h10, 5'd3, 1'b1, 32'h20, 32'h20, 32'h44, 32'h44};
        vecs[3] = '{mk(4'd1, 5'd3, 5'd2, 1'b1, 1'b1, 32'h33, 32'h44, 5'd7, 1'b0),
                    5'd0, 1'b1, 32'h10, 5'd0, 1'b1, 32'h20, 32'h33, 32'h44, 32'h44};
        vecs[4] = '{mk(4'd2, 5'd1, 5'd2, 1'b1, 1'b1, 32'h11, 32'h9, 5'd7, 1'b0),
                    5'd1, 1'b1, 32'hDEAD, 5'd0, 1'b0, 32'd0, 32'h100, 32'hFFFF_FFFC, 32'h9};
        vecs[4].ins.sel_pc = 1'b1; vecs[4].ins.sel_imm = 1'b1;
        vecs[4].ins.pc = 32'h100;  vecs[4].ins.imm = 32'hFFFF_FFFC;
        vecs[5] = '{mk(4'd3, 5'd6, 5'd2, 1'b0, 1'b1, 32'h66, 32'h22, 5'd7, 1'b0),
                    5'd6, 1'b1, 32'hBEEF, 5'd0, 1'b0, 32'd0, 32'h66, 32'h22, 32'h22};
        vecs[6] = '{mk(4'd4, 5'd1, 5'd6, 1'b1, 1'b1, 32'h1, 32'h66, 5'd7, 1'b0),
                    5'd2, 1'b1, 32'h5, 5'd6, 1'b1, 32'hCAFE, 32'h1, 32'hCAFE, 32'hCAFE};

        #3;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_alu_ctrl", {28'd0, ex_alu_ctrl}, 32'd0);
        chk("rst_rd", {27'd0, ex_rd}, 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_gated", {30'd0, ex_reg_write, ex_mem_read}, 32'd0);
        chk("rst_stall", {31'd0, stall_id}, 32'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            apply_id(vecs[i].ins);
            set_fwd(vecs[i].mrd, vecs[i].mwe, vecs[i].mres, vecs[i].wrd, vecs[i].wwe, vecs[i].wres);
            @(posedge clk); #1;
            id_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), {31'd0, ex_valid}, 32'd1);
            chk($sformatf("vec%0d_alu", i), {28'd0, ex_alu_ctrl}, {28'd0, vecs[i].ins.alu});
            chk($sformatf("vec%0d_opA", i), ex_op_A, vecs[i].exp_a);
            chk($sformatf("vec%0d_opB", i), ex_op_B, vecs[i].exp_b);
            chk($sformatf("vec%0d_store", i), ex_store_data, vecs[i].exp_st);
        end

        // Load-use: exactly one stall cycle, then the consumer issues with mem_result forwarded
        set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
        @(posedge clk); #1; apply_id(mk(4'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd4, 1'b1));
        @(posedge clk); #1; apply_id(mk(4'd0, 5'd1, 5'd4, 1'b1, 1'b1, 32'h1, 32'h111, 5'd6, 1'b0));
        @(negedge clk); chk("lu_stall_on", {31'd0, stall_id}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        chk("lu_stall_off", {31'd0, stall_id}, 32'd0);
        @(posedge clk); #1; id_valid = 1'b0; set_fwd(5'd4, 1'b1, 32'hABCD, 5'd0, 1'b0, 32'd0);
        @(negedge clk);
        chk("lu_issue_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_issue_opB", ex_op_B, 32'hABCD);
        chk("lu_issue_opA", ex_op_A, 32'h1);

        // Flush beats hazard
        set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
        @(posedge clk); #1; apply_id(mk(4'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd4, 1'b1));
        @(posedge clk); #1; apply_id(mk(4'd0, 5'd4, 5'd2, 1'b1, 1'b0, 32'd0, 32'd0, 5'd6, 1'b0));
        flush = 1'b1;
        @(negedge clk); chk("flush_no_stall", {31'd0, stall_id}, 32'd0);
        @(posedge clk); #1; flush = 1'b0; id_valid = 1'b0;
        @(negedge clk); chk("flush_kill", {31'd0, ex_valid}, 32'd0);

        // Load followed by independent instruction
        @(posedge clk); #1; apply_id(mk(4'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd4, 1'b1));
        @(posedge clk); #1; apply_id(mk(4'd0, 5'd2, 5'd3, 1'b1, 1'b1, 32'd0, 32'd0, 5'd6, 1'b0));
        @(negedge clk); chk("indep_no_stall", {31'd0, stall_id}, 32'd0);

        // Asynchronous reset in the middle of a stall
        @(posedge clk); #1; apply_id(mk(4'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd5, 1'b1));
        @(posedge clk); #1; apply_id(mk(4'd0, 5'd5, 5'd0, 1'b1, 1'b0, 32'd0, 32'd0, 5'd6, 1'b0));
        @(negedge clk);
        chk("pre_rst_state", {29'd0, ex_valid, ex_mem_read, stall_id}, 32'd7);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_drop", {28'd0, ex_valid, ex_reg_write, ex_mem_read, stall_id}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Randomized traffic against the reference model
        m_ex = '0; cur = '0; cur_flush = 1'b0; exp_hz = 1'b0;
        apply_id(cur); flush = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (!(cur_flush || exp_hz)) m_ex = cur;
            else m_ex.valid = 1'b0;
            t = '0;
            t.valid = ($urandom % 4) != 0; t.alu = 4'($urandom);
            t.rs1 = 5'($urandom_range(7, 0)); t.rs2 = 5'($urandom_range(7, 0));
            t.use1 = 1'($urandom); t.use2 = 1'($urandom);
            t.d1 = $urandom; t.d2 = $urandom; t.imm = $urandom; t.pc = $urandom;
            t.sel_imm = 1'($urandom); t.sel_pc = 1'($urandom);
            t.rd = 5'($urandom_range(7, 0)); t.rw = 1'($urandom); t.mr = ($urandom % 3) == 0;
            cur = t; cur_flush = ($urandom % 8) == 0;
            apply_id(cur); flush = cur_flush;
            set_fwd(5'($urandom_range(7, 0)), 1'($urandom), $urandom,
                    5'($urandom_range(7, 0)), 1'($urandom), $urandom);
            @(negedge clk);
            exp_hz = m_ex.valid && m_ex.mr && m_ex.rd != 5'd0 && cur.valid &&
                     ((cur.use1 && cur.rs1 == m_ex.rd) || (cur.use2 && cur.rs2 == m_ex.rd));
            exp_stall = exp_hz && !cur_flush;
            chk("rnd_stall", {31'd0, stall_id}, {31'd0, exp_stall});
            chk("rnd_valid", {31'd0, ex_valid}, {31'd0, m_ex.valid});
            chk("rnd_gated", {30'd0, ex_reg_write, ex_mem_read},
                {30'd0, m_ex.valid && m_ex.rw, m_ex.valid && m_ex.mr});
            if (m_ex.valid) begin
                ea = m_ex.sel_pc ? m_ex.pc : ref_operand(m_ex.use1, m_ex.rs1, m_ex.d1);
                eb = ref_operand(m_ex.use2, m_ex.rs2, m_ex.d2);
                chk("rnd_opA", ex_op_A, ea);
                chk("rnd_opB", ex_op_B, m_ex.sel_imm ? m_ex.imm : eb);
                chk("rnd_store", ex_store_data, eb);
                chk("rnd_ctl", {19'd0, ex_alu_ctrl, ex_rd, 4'd0}, {19'd0, m_ex.alu, m_ex.rd, 4'd0});
                chk("rnd_pc", ex_pc, m_ex.pc);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
